// File: rtl/hcp_frame_arbiter_if.sv
// Bundle of the framed input channels and the merged output stream.
// master drives channel beats and the mode; slave is the arbiter.
interface hcp_frame_arbiter_if #(
  parameter int CH_NUM = 4,
  parameter int DW     = 8
);
  localparam int GW = $clog2(CH_NUM);

  logic [CH_NUM*(DW+1)-1:0] iv_data;
  logic [CH_NUM-1:0]        iv_data_wr;
  logic                     i_prio_mode;
  logic [DW:0]              ov_data;
  logic                     o_data_wr;
  logic [GW-1:0]            ov_grant_ch;
  logic [CH_NUM-1:0]        ov_drop_pulse;

  modport master (
    output iv_data, iv_data_wr, i_prio_mode,
    input  ov_data, o_data_wr, ov_grant_ch, ov_drop_pulse
  );

  modport slave (
    input  iv_data, iv_data_wr, i_prio_mode,
    output ov_data, o_data_wr, ov_grant_ch, ov_drop_pulse
  );
endinterface

// File: rtl/hcp_frame_arbiter.sv
// Store-and-forward merge of CH_NUM framed beat streams onto one
// output, round-robin or strict priority, with per-channel drop pulses.
module hcp_frame_arbiter #(
  parameter int CH_NUM = 4,
  parameter int DW     = 8,
  parameter int DEPTH  = 64
) (
  input logic i_clk,
  input logic i_rst_n,
  hcp_frame_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int GW = $clog2(CH_NUM);

  typedef enum logic [1:0] {IDLE, SEND, GAP} st_t;

  st_t           state, nxt_state;
  logic [GW-1:0] gnt, nxt_gnt, pick;
  logic          found;
  logic          first;

  logic [CH_NUM-1:0][DW:0] rd_beat;
  logic [CH_NUM-1:0]       cnt_nz;
  logic [CH_NUM-1:0]       commit;
  logic [CH_NUM-1:0]       done;
  logic [CH_NUM-1:0]       drop;

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    logic [DW:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, cm_ptr, rd_ptr;
    logic [AW-1:0] nxt_wr, nxt_cm, wr_addr;
    logic [AW:0]   cnt;
    logic          open, skip, prev;
    logic          nxt_open, nxt_skip;
    logic          wr_en, start, cmt, drp;
    logic          vld, head, rd_en, full, cm_full;
    logic [DW:0]   beat;

    assign beat       = bus.iv_data[k*(DW+1) +: DW+1];
    assign vld        = bus.iv_data_wr[k];
    assign head       = beat[DW];
    assign full       = (wr_ptr + 1'b1) == rd_ptr;
    assign cm_full    = (cm_ptr + 1'b1) == rd_ptr;
    assign rd_en      = (state == SEND) && (gnt == GW'(k));
    assign rd_beat[k] = mem[rd_ptr];
    assign cnt_nz[k]  = cnt != '0;
    assign commit[k]  = cmt;
    assign drop[k]    = drp;
    assign done[k]    = rd_en && !first && rd_beat[k][DW];

    // A delimiter after an idle cycle is a new head; one that
    // directly follows a beat of the open frame is its tail.
    always_comb begin
      nxt_wr   = wr_ptr;
      nxt_cm   = cm_ptr;
      nxt_open = open;
      nxt_skip = skip;
      wr_addr  = wr_ptr;
      wr_en    = 1'b0;
      start    = 1'b0;
      cmt      = 1'b0;
      drp      = 1'b0;
      if (vld) begin
        unique case (1'b1)
          skip: begin
            nxt_skip = !head;
            start    = head && !prev;
          end
          open: begin
            if (head && !prev) begin
              drp      = 1'b1;
              nxt_wr   = cm_ptr;
              nxt_open = 1'b0;
              start    = 1'b1;
            end else if (full) begin
              drp      = 1'b1;
              nxt_wr   = cm_ptr;
              nxt_open = 1'b0;
              nxt_skip = !head;
            end else begin
              wr_en  = 1'b1;
              nxt_wr = wr_ptr + 1'b1;
              if (head) begin
                cmt      = 1'b1;
                nxt_cm   = wr_ptr + 1'b1;
                nxt_open = 1'b0;
              end
            end
          end
          default: start = head;
        endcase
        if (start) begin
          if (cm_full) begin
            drp      = 1'b1;
            nxt_skip = 1'b1;
          end else begin
            wr_en    = 1'b1;
            wr_addr  = cm_ptr;
            nxt_wr   = cm_ptr + 1'b1;
            nxt_open = 1'b1;
          end
        end
      end
    end

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        wr_ptr <= '0;
        cm_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        open   <= 1'b0;
        skip   <= 1'b0;
        prev   <= 1'b0;
      end else begin
        wr_ptr <= nxt_wr;
        cm_ptr <= nxt_cm;
        open   <= nxt_open;
        skip   <= nxt_skip;
        prev   <= vld;
        if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        cnt <= cnt + (AW+1)'(cmt) - (AW+1)'(done[k]);
      end
    end

    always_ff @(posedge i_clk) begin
      if (wr_en) mem[wr_addr] <= beat;
    end
  end

  always_comb begin
    pick  = gnt;
    found = 1'b0;
    for (int i = 0; i < CH_NUM; i++) begin
      logic [GW-1:0] c;
      c = bus.i_prio_mode ? GW'(i)
                          : GW'((int'(gnt) + 1 + i) % CH_NUM);
      if (!found && cnt_nz[c]) begin
        found = 1'b1;
        pick  = c;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state             <= IDLE;
      gnt               <= GW'(CH_NUM - 1);
      first             <= 1'b0;
      bus.ov_drop_pulse <= '0;
    end else begin
      state             <= nxt_state;
      gnt               <= nxt_gnt;
      first             <= state == IDLE;
      bus.ov_drop_pulse <= drop;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_gnt   = gnt;
    unique case (state)
      IDLE: if (found) begin
        nxt_state = SEND;
        nxt_gnt   = pick;
      end
      SEND: if (done[gnt]) nxt_state = GAP;
      GAP:  nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_comb begin
    bus.o_data_wr = 1'b0;
    bus.ov_data   = '0;
    if (state == SEND) begin
      bus.o_data_wr = 1'b1;
      bus.ov_data   = rd_beat[gnt];
    end
  end

  assign bus.ov_grant_ch = gnt;
endmodule

// File: tb/tb_hcp_frame_arbiter.sv
// Randomized and directed bench for hcp_frame_arbiter against a
// queue-based model of buffering, eligibility and arbitration.
module tb_hcp_frame_arbiter;
  localparam int CH_NUM = 4;
  localparam int DW     = 8;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  hcp_frame_arbiter_if #(.CH_NUM(CH_NUM), .DW(DW)) bus();

  hcp_frame_arbiter #(
    .CH_NUM(CH_NUM),
    .DW(DW),
    .DEPTH(DEPTH)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );

  int n_chk = 0;
  int n_pass = 0;

  // stimulus per channel: bit 9 = write strobe, bits 8:0 = beat
  logic [9:0] txq [CH_NUM][$];

  int         used    [CH_NUM];
  int         pend_rd [CH_NUM];
  bit         open_m  [CH_NUM];
  bit         skip_m  [CH_NUM];
  bit         prev_m  [CH_NUM];
  logic [8:0] ob [CH_NUM][$];
  logic [8:0] bq [CH_NUM][$];
  int         fe [CH_NUM][$];
  int         fl [CH_NUM][$];
  logic [8:0] exp_q [$];
  int         cur_ch;
  int         next_free;
  int         last_g;
  bit         mode_v;
  bit         mode_req;
  logic [CH_NUM-1:0] pulse_nx;
  logic [CH_NUM-1:0] exp_pulse;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0d: got %0h want %0h", tag, edge_n, got, exp);
  endtask

  function automatic void m_reset(input int e);
    for (int k = 0; k < CH_NUM; k++) begin
      used[k] = 0;
      pend_rd[k] = 0;
      open_m[k] = 0;
      skip_m[k] = 0;
      prev_m[k] = 0;
      ob[k].delete();
      bq[k].delete();
      fe[k].delete();
      fl[k].delete();
      txq[k].delete();
    end
    exp_q.delete();
    next_free = e + 1;
    last_g = CH_NUM - 1;
    pulse_nx = '0;
  endfunction

  function automatic void m_drop(input int k);
    used[k] -= ob[k].size();
    ob[k].delete();
    open_m[k] = 0;
    pulse_nx[k] = 1'b1;
  endfunction

  function automatic void m_start(input int k, input logic [8:0] b);
    if (used[k] == DEPTH - 1) begin
      pulse_nx[k] = 1'b1;
      skip_m[k] = 1;
    end else begin
      ob[k].push_back(b);
      used[k]++;
      open_m[k] = 1;
    end
  endfunction

  function automatic void m_beat(input int k, input logic [8:0] b,
                                 input int w);
    bit hd;
    hd = b[DW];
    if (skip_m[k]) begin
      if (hd) begin
        skip_m[k] = 0;
        if (!prev_m[k]) m_start(k, b);
      end
    end else if (open_m[k]) begin
      if (hd && !prev_m[k]) begin
        m_drop(k);
        m_start(k, b);
      end else if (used[k] == DEPTH - 1) begin
        m_drop(k);
        if (!hd) skip_m[k] = 1;
      end else begin
        ob[k].push_back(b);
        used[k]++;
        if (hd) begin
          for (int i = 0; i < ob[k].size(); i++) bq[k].push_back(ob[k][i]);
          fl[k].push_back(ob[k].size());
          fe[k].push_back(w);
          ob[k].delete();
          open_m[k] = 0;
        end
      end
    end else if (hd) begin
      m_start(k, b);
    end
  endfunction

  task automatic out_check(input int n);
    int pick;
    int c;
    int len;
    logic [8:0] e;
    pick = -1;
    if (exp_q.size() == 0 && n >= next_free) begin
      for (int i = 0; i < CH_NUM; i++) begin
        c = mode_v ? i : (last_g + 1 + i) % CH_NUM;
        if (pick < 0 && fe[c].size() > 0 && fe[c][0] <= n - 1) pick = c;
      end
      if (pick >= 0) begin
        len = fl[pick].pop_front();
        void'(fe[pick].pop_front());
        for (int j = 0; j < len; j++) exp_q.push_back(bq[pick].pop_front());
        cur_ch = pick;
        last_g = pick;
      end
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("o_data_wr", 32'(bus.o_data_wr), 32'd1);
      chk("ov_data", 32'(bus.ov_data), 32'(e));
      pend_rd[cur_ch]++;
      if (exp_q.size() == 0) next_free = n + 3;
    end else begin
      chk("idle_wr", 32'(bus.o_data_wr), 32'd0);
      chk("idle_data", 32'(bus.ov_data), 32'd0);
    end
    chk("grant", 32'(bus.ov_grant_ch), 32'(last_g));
    chk("drop_pulse", 32'(bus.ov_drop_pulse), 32'(exp_pulse));
  endtask

  task automatic tick(input bit rst_next);
    logic [CH_NUM*(DW+1)-1:0] dv;
    logic [CH_NUM-1:0] wv;
    logic [9:0] e;
    int n;
    @(negedge clk);
    n = edge_n;
    for (int k = 0; k < CH_NUM; k++) begin
      used[k] -= pend_rd[k];
      pend_rd[k] = 0;
    end
    out_check(n);
    mode_v = mode_req;
    dv = '0;
    wv = '0;
    pulse_nx = '0;
    if (rst_next) begin
      m_reset(n + 1);
    end else begin
      for (int k = 0; k < CH_NUM; k++) begin
        e = 10'h0;
        if (txq[k].size() > 0) e = txq[k].pop_front();
        if (e[9]) begin
          wv[k] = 1'b1;
          dv[k*(DW+1) +: DW+1] = e[8:0];
          m_beat(k, e[8:0], n + 1);
        end
        prev_m[k] = e[9];
      end
    end
    exp_pulse = pulse_nx;
    rst_n = !rst_next;
    bus.iv_data = dv;
    bus.iv_data_wr = wv;
    bus.i_prio_mode = mode_v;
  endtask

  function automatic void push_idle(input int k, input int cnt);
    for (int i = 0; i < cnt; i++) txq[k].push_back(10'h0);
  endfunction

  function automatic void push_mid(input int k);
    txq[k].push_back({2'b10, 8'($urandom)});
  endfunction

  function automatic void push_frame(input int k, input int len);
    txq[k].push_back({2'b11, 8'($urandom)});
    for (int i = 0; i < len - 2; i++) push_mid(k);
    txq[k].push_back({2'b11, 8'($urandom)});
  endfunction

  function automatic void push_trunc(input int k, input int mids);
    txq[k].push_back({2'b11, 8'($urandom)});
    for (int i = 0; i < mids; i++) push_mid(k);
    push_idle(k, 1);
  endfunction

  function automatic void gen(input int k);
    int r;
    r = $urandom_range(0, 99);
    if (r < 45) push_idle(k, $urandom_range(1, 12));
    else if (r < 80) push_frame(k, $urandom_range(2, 8));
    else if (r < 88) push_trunc(k, $urandom_range(0, 3));
    else if (r < 94) begin
      push_idle(k, 1);
      push_mid(k);
    end else push_frame(k, $urandom_range(10, 20));
  endfunction

  function automatic bit model_busy();
    bit b;
    b = exp_q.size() > 0;
    for (int k = 0; k < CH_NUM; k++)
      if (txq[k].size() > 0 || fe[k].size() > 0) b = 1;
    return b;
  endfunction

  task automatic drain();
    int i;
    i = 0;
    while (i < 400 && model_busy()) begin
      tick(1'b0);
      i++;
    end
    repeat (4) tick(1'b0);
  endtask

  task automatic do_reset();
    tick(1'b1);
    tick(1'b1);
    tick(1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int i;
    bus.iv_data = '0;
    bus.iv_data_wr = '0;
    bus.i_prio_mode = 1'b0;
    mode_v = 0;
    mode_req = 0;
    exp_pulse = '0;
    cur_ch = 0;
    m_reset(0);
    do_reset();
    repeat (3) tick(1'b0);

    // single 6-beat frame on ch2
    txq[2].push_back(10'h3AA);
    for (int j = 0; j < 4; j++) push_mid(2);
    txq[2].push_back(10'h355);
    drain();

    // round-robin, three channels committing together
    do_reset();
    mode_req = 0;
    push_frame(0, 4);
    push_frame(1, 4);
    push_frame(3, 4);
    push_idle(0, 6);
    push_frame(0, 4);
    drain();

    // strict priority
    do_reset();
    mode_req = 1;
    push_frame(3, 4);
    push_idle(1, 6);
    push_frame(1, 4);
    push_idle(2, 1);
    push_frame(2, 6);
    push_idle(0, 9);
    push_frame(0, 3);
    push_idle(1, 5);
    push_frame(1, 3);
    drain();

    // overflow then a good frame on ch1
    do_reset();
    mode_req = 0;
    push_frame(1, 20);
    push_idle(1, 2);
    push_frame(1, 4);
    drain();

    // malformed: broken frame, new head after a gap, stray mid beat
    push_trunc(0, 2);
    txq[0].push_back({2'b11, 8'h21});
    push_mid(0);
    txq[0].push_back({2'b11, 8'h43});
    push_idle(0, 3);
    push_mid(0);
    drain();

    // reset in the middle of an 8-beat send
    push_frame(0, 8);
    i = 0;
    while (i < 100 && exp_q.size() != 5) begin
      tick(1'b0);
      i++;
    end
    tick(1'b1);
    tick(1'b0);
    repeat (3) tick(1'b0);
    push_frame(2, 5);
    drain();

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < CH_NUM; k++)
        if (txq[k].size() == 0) gen(k);
      if ($urandom_range(0, 49) == 0) mode_req = !mode_req;
      if ($urandom_range(0, 1999) == 0) do_reset();
      else tick(1'b0);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
